// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write arbiter and its dump sequencer.
// Dump hardware is only built when RF_DUMP_EN is defined.
package rf_arb_pkg;

    localparam int REG_ZERO   = 0;
    localparam int REG_RA     = 31;
    localparam int LINK_SHIFT = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DUMP  = 2'd2,
        DONE  = 2'd3
    } dump_state_t;

    // Winner of the single write slot on a given edge.
    typedef enum logic [2:0] {
        SRC_NONE = 3'd0,
        SRC_WB   = 3'd1,
        SRC_JBUF = 3'd2,
        SRC_JAL  = 3'd3,
        SRC_DBG  = 3'd4
    } wr_src_t;

endpackage

// File: rtl/rf_dump_seq.sv
// Register dump sequencer: drains pending JAL work, walks every register through a read port,
// and flags WB writes that land while the walk is in progress.
module rf_dump_seq
    import rf_arb_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int DW    = 32,
    parameter int AW    = 5
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_dump_req,
    input  logic          i_buf_empty,
    input  logic          i_wb_we,
    input  logic          i_wb_wr,
    input  logic [DW-1:0] i_dump_rdata,
    output logic          o_fsm_idle,
    output logic [AW-1:0] o_dump_raddr,
    output logic          o_dump_valid,
    output logic [AW-1:0] o_dump_idx,
    output logic [DW-1:0] o_dump_data,
    output logic          o_dump_done,
    output logic          o_dump_dirty
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    dump_state_t   r_state;
    dump_state_t   w_next;
    logic [AW-1:0] r_idx;
    logic          r_valid;
    logic [AW-1:0] r_idx_out;
    logic [DW-1:0] r_data;
    logic          r_dirty;

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_dump_req)              w_next = DRAIN;
            DRAIN:   if (i_buf_empty && !i_wb_we) w_next = DUMP;
            DUMP:    if (r_idx == LAST_IDX)       w_next = DONE;
            DONE:                                 w_next = IDLE;
            default:                              w_next = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_valid   <= 1'b0;
            r_idx_out <= '0;
            r_data    <= '0;
            r_dirty   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_idx   <= (r_state == DUMP) ? r_idx + AW'(1) : '0;
            r_valid <= (r_state == DUMP);
            if (r_state == DUMP) begin
                r_idx_out <= r_idx;
                r_data    <= i_dump_rdata;
            end
            if (r_state == IDLE && i_dump_req)
                r_dirty <= 1'b0;
            else if (r_state == DUMP && i_wb_wr)
                r_dirty <= 1'b1;
        end
    end

    assign o_fsm_idle   = (r_state == IDLE);
    assign o_dump_raddr = (r_state == DUMP) ? r_idx : '0;
    assign o_dump_valid = r_valid;
    assign o_dump_idx   = r_idx_out;
    assign o_dump_data  = r_data;
    assign o_dump_done  = (r_state == DONE);
    assign o_dump_dirty = r_dirty;

endmodule

// File: rtl/rf_write_arbiter.sv
// Fixed-priority arbiter (WB > JAL > debug) for the register file's single write port, with a
// one-entry JAL holding buffer. Define RF_DUMP_EN to add the register dump sequencer.
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int DW    = 32,
    parameter int AW    = 5
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          wb_we,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    input  logic          jal_we,
    input  logic [DW-1:0] jal_link,
    input  logic          dbg_valid,
    output logic          dbg_ready,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_data,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic          stall,
    output logic          ovf_err,
    input  logic          dump_req,
    output logic [AW-1:0] dump_raddr,
    input  logic [DW-1:0] dump_rdata,
    output logic          dump_valid,
    output logic [AW-1:0] dump_idx,
    output logic [DW-1:0] dump_data,
    output logic          dump_done,
    output logic          dump_dirty
);

    localparam logic [AW-1:0] ADDR_ZERO = AW'(REG_ZERO);
    localparam logic [AW-1:0] ADDR_RA   = AW'(REG_RA);

    logic          r_jal_buf_vld;
    logic [DW-1:0] r_jal_buf_data;
    logic          w_fsm_idle;
    logic          w_wb_wr;
    logic          w_jal_live;
    logic [DW-1:0] w_jal_data;
    logic          w_dbg_wr;
    wr_src_t       w_src;
    logic [AW-1:0] w_waddr;
    logic [DW-1:0] w_wdata;

    // Writes to register 0 never occupy the slot.
    assign w_wb_wr    = wb_we && (wb_addr != ADDR_ZERO);
    assign w_jal_live = jal_we && !stall;
    assign w_jal_data = jal_link << LINK_SHIFT;
    assign w_dbg_wr   = dbg_valid && dbg_ready && (dbg_addr != ADDR_ZERO);

    assign stall     = r_jal_buf_vld || !w_fsm_idle;
    assign dbg_ready = RST_N && w_fsm_idle && !wb_we && !jal_we && !r_jal_buf_vld;

    always_comb begin
        w_src = SRC_NONE;
        if (w_wb_wr)
            w_src = SRC_WB;
        else if (r_jal_buf_vld)
            w_src = SRC_JBUF;
        else if (w_jal_live)
            w_src = SRC_JAL;
        else if (w_dbg_wr)
            w_src = SRC_DBG;
    end

    always_comb begin
        w_waddr = '0;
        w_wdata = '0;
        case (w_src)
            SRC_WB:   begin w_waddr = wb_addr;  w_wdata = wb_data;        end
            SRC_JBUF: begin w_waddr = ADDR_RA;  w_wdata = r_jal_buf_data; end
            SRC_JAL:  begin w_waddr = ADDR_RA;  w_wdata = w_jal_data;     end
            SRC_DBG:  begin w_waddr = dbg_addr; w_wdata = dbg_data;       end
            default:  begin w_waddr = '0;       w_wdata = '0;             end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rf_we          <= 1'b0;
            rf_waddr       <= '0;
            rf_wdata       <= '0;
            r_jal_buf_vld  <= 1'b0;
            r_jal_buf_data <= '0;
            ovf_err        <= 1'b0;
        end else begin
            rf_we <= (w_src != SRC_NONE);
            if (w_src != SRC_NONE) begin
                rf_waddr <= w_waddr;
                rf_wdata <= w_wdata;
            end

            // A WB write to the link register supersedes an older buffered JAL.
            if (w_wb_wr && w_jal_live) begin
                r_jal_buf_vld  <= 1'b1;
                r_jal_buf_data <= w_jal_data;
            end else if (r_jal_buf_vld && (!w_wb_wr || wb_addr == ADDR_RA)) begin
                r_jal_buf_vld <= 1'b0;
            end

            if (jal_we && stall)
                ovf_err <= 1'b1;
        end
    end

`ifdef RF_DUMP_EN
    rf_dump_seq #(
        .NREGS (NREGS),
        .DW    (DW),
        .AW    (AW)
    ) u_dump_seq (
        .i_clk        (CLK),
        .i_rst_n      (RST_N),
        .i_dump_req   (dump_req),
        .i_buf_empty  (!r_jal_buf_vld),
        .i_wb_we      (wb_we),
        .i_wb_wr      (w_wb_wr),
        .i_dump_rdata (dump_rdata),
        .o_fsm_idle   (w_fsm_idle),
        .o_dump_raddr (dump_raddr),
        .o_dump_valid (dump_valid),
        .o_dump_idx   (dump_idx),
        .o_dump_data  (dump_data),
        .o_dump_done  (dump_done),
        .o_dump_dirty (dump_dirty)
    );
`else
    logic w_unused_dump;

    assign w_unused_dump = ^{dump_req, dump_rdata, (NREGS > 0)};
    assign w_fsm_idle    = 1'b1;
    assign dump_raddr    = '0;
    assign dump_valid    = 1'b0;
    assign dump_idx      = '0;
    assign dump_data     = '0;
    assign dump_done     = 1'b0;
    assign dump_dirty    = 1'b0;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter; dump scenarios are compiled in with RF_DUMP_EN.
module tb_rf_write_arbiter;

    localparam int NREGS = 32;
    localparam int DW    = 32;
    localparam int AW    = 5;

    logic          CLK;
    logic          RST_N;
    logic          wb_we;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          jal_we;
    logic [DW-1:0] jal_link;
    logic          dbg_valid;
    logic          dbg_ready;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_data;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          stall;
    logic          ovf_err;
    logic          dump_req;
    logic [AW-1:0] dump_raddr;
    logic [DW-1:0] dump_rdata;
    logic          dump_valid;
    logic [AW-1:0] dump_idx;
    logic [DW-1:0] dump_data;
    logic          dump_done;
    logic          dump_dirty;

    int n_checks = 0;
    int n_fail   = 0;

    // Register file model fed by the arbiter's write port.
    logic [DW-1:0] rf_mem [NREGS] = '{default: '0};

    always @(posedge CLK)
        if (rf_we) rf_mem[rf_waddr] <= rf_wdata;

    assign dump_rdata = rf_mem[dump_raddr];

    rf_write_arbiter #(
        .NREGS (NREGS),
        .DW    (DW),
        .AW    (AW)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .jal_we     (jal_we),
        .jal_link   (jal_link),
        .dbg_valid  (dbg_valid),
        .dbg_ready  (dbg_ready),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .stall      (stall),
        .ovf_err    (ovf_err),
        .dump_req   (dump_req),
        .dump_raddr (dump_raddr),
        .dump_rdata (dump_rdata),
        .dump_valid (dump_valid),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .dump_done  (dump_done),
        .dump_dirty (dump_dirty)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_write(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        check({tag, "_we"}, rf_we, 1'b1);
        check({tag, "_addr"}, rf_waddr, addr);
        check({tag, "_data"}, rf_wdata, data);
    endtask

    initial begin
        int beats;
        int dones;
        int found;

        RST_N     = 1'b0;
        wb_we     = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
        jal_we    = 1'b0;
        jal_link  = '0;
        dbg_valid = 1'b1;
        dbg_addr  = 5'd3;
        dbg_data  = 32'h1;
        dump_req  = 1'b0;

        // Reset state
        step();
        check("rst_rf_we", rf_we, 1'b0);
        check("rst_rf_waddr", rf_waddr, '0);
        check("rst_rf_wdata", rf_wdata, '0);
        check("rst_stall", stall, 1'b0);
        check("rst_ovf", ovf_err, 1'b0);
        check("rst_dbg_ready", dbg_ready, 1'b0);
        check("rst_dump_valid", dump_valid, 1'b0);
        check("rst_dump_done", dump_done, 1'b0);
        check("rst_dump_dirty", dump_dirty, 1'b0);
        dbg_valid = 1'b0;
        RST_N     = 1'b1;
        step();
        check("idle_rf_we", rf_we, 1'b0);
        check("idle_dbg_ready", dbg_ready, 1'b1);

        // WB and JAL collide: WB first, buffered JAL next, stall for one cycle
        wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h11;
        jal_we = 1'b1; jal_link = 32'h40;
        #1;
        check("col_dbg_ready_low", dbg_ready, 1'b0);
        step();
        wb_we = 1'b0; jal_we = 1'b0;
        expect_write("col_wb", 5'd5, 32'h11);
        check("col_stall_1", stall, 1'b1);
        step();
        expect_write("col_jal", 5'd31, 32'h100);
        check("col_stall_0", stall, 1'b0);
        step();
        check("col_quiet", rf_we, 1'b0);

        // Buffered JAL discarded by a WB write to r31
        wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h22;
        jal_we = 1'b1; jal_link = 32'h10;
        step();
        jal_we = 1'b0;
        check("drop_stall_1", stall, 1'b1);
        wb_addr = 5'd31; wb_data = 32'hAA;
        step();
        wb_we = 1'b0;
        expect_write("drop_wb31", 5'd31, 32'hAA);
        check("drop_stall_0", stall, 1'b0);
        step();
        check("drop_no_jal", rf_we, 1'b0);

        // Second JAL while stalled: ignored, sticky overflow
        wb_we = 1'b1; wb_addr = 5'd6; wb_data = 32'h33;
        jal_we = 1'b1; jal_link = 32'h20;
        step();
        wb_we = 1'b0;
        check("ovf_pre", ovf_err, 1'b0);
        jal_link = 32'h99;
        step();
        jal_we = 1'b0;
        expect_write("ovf_first_jal", 5'd31, 32'h80);
        check("ovf_set", ovf_err, 1'b1);
        check("ovf_stall_0", stall, 1'b0);
        step();
        check("ovf_no_second", rf_we, 1'b0);
        check("ovf_sticky", ovf_err, 1'b1);

        // Live JAL alone; upper link bits fall off the shift
        jal_we = 1'b1; jal_link = 32'hC000_0001;
        #1;
        check("live_dbg_ready_low", dbg_ready, 1'b0);
        step();
        jal_we = 1'b0;
        expect_write("live_jal", 5'd31, 32'h4);
        check("live_stall", stall, 1'b0);

        // WB to r0 takes no slot, so a concurrent JAL goes straight through
        wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEAD;
        jal_we = 1'b1; jal_link = 32'h3;
        step();
        wb_we = 1'b0; jal_we = 1'b0;
        expect_write("r0_jal", 5'd31, 32'hC);
        check("r0_stall", stall, 1'b0);

        // Debug writes
        dbg_valid = 1'b1; dbg_addr = 5'd0; dbg_data = 32'h5;
        #1;
        check("dbg0_ready", dbg_ready, 1'b1);
        step();
        check("dbg0_no_write", rf_we, 1'b0);
        dbg_addr = 5'd7; dbg_data = 32'h9;
        step();
        expect_write("dbg7", 5'd7, 32'h9);
        dbg_addr = 5'd8; dbg_data = 32'h77;
        wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'h44;
        #1;
        check("dbg_ready_wb", dbg_ready, 1'b0);
        step();
        wb_we = 1'b0;
        expect_write("dbg_wb_wins", 5'd9, 32'h44);
        step();
        dbg_valid = 1'b0;
        expect_write("dbg8", 5'd8, 32'h77);
        step();
        check("dbg_quiet", rf_we, 1'b0);

`ifdef RF_DUMP_EN
        // Preload reg[i] = i*3 through the debug port
        for (int i = 1; i < NREGS; i++) begin
            dbg_valid = 1'b1; dbg_addr = AW'(i); dbg_data = 32'(i * 3);
            step();
        end
        dbg_valid = 1'b0;
        step();

        // Full dump
        dump_req = 1'b1;
        step();
        dump_req = 1'b0;
        check("dump_stall_drain", stall, 1'b1);
        check("dump_dbg_ready", dbg_ready, 1'b0);
        beats = 0;
        dones = 0;
        for (int c = 0; c < 60 && dones == 0; c++) begin
            step();
            if (dump_valid) begin
                check("dump_idx", 32'(dump_idx), 32'(beats));
                check("dump_data", dump_data, 32'(beats * 3));
                beats++;
            end
            if (dump_done) dones++;
        end
        check("dump_beats", 32'(beats), 32'd32);
        check("dump_done_seen", 32'(dones), 32'd1);
        step();
        check("dump_done_pulse", dump_done, 1'b0);
        check("dump_stall_end", stall, 1'b0);
        check("dump_clean", dump_dirty, 1'b0);

        // WB write during DUMP sets dump_dirty
        dump_req = 1'b1;
        step();
        dump_req = 1'b0;
        found = 0;
        for (int c = 0; c < 40 && found == 0; c++) begin
            step();
            if (dump_valid && dump_idx == 5'd5) found = 1;
        end
        check("dirty_reach_idx5", 32'(found), 32'd1);
        wb_we = 1'b1; wb_addr = 5'd4; wb_data = 32'h7;
        step();
        wb_we = 1'b0;
        expect_write("dirty_wb", 5'd4, 32'h7);
        check("dirty_set", dump_dirty, 1'b1);
        found = 0;
        for (int c = 0; c < 60 && found == 0; c++) begin
            step();
            if (dump_done) found = 1;
        end
        check("dirty_dump_done", 32'(found), 32'd1);
        step();
        check("dirty_sticky", dump_dirty, 1'b1);
        dump_req = 1'b1;
        step();
        dump_req = 1'b0;
        check("dirty_cleared", dump_dirty, 1'b0);

        // Reset in the middle of a dump
        found = 0;
        for (int c = 0; c < 40 && found == 0; c++) begin
            step();
            if (dump_valid && dump_idx == 5'd10) found = 1;
        end
        check("rst_reach_idx10", 32'(found), 32'd1);
        RST_N = 1'b0;
        step();
        RST_N = 1'b1;
        check("midrst_stall", stall, 1'b0);
        check("midrst_valid", dump_valid, 1'b0);
        check("midrst_done", dump_done, 1'b0);
        check("midrst_raddr", 32'(dump_raddr), 32'd0);
        check("midrst_ovf", ovf_err, 1'b0);
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (dump_done) dones++;
        end
        check("midrst_no_done", 32'(dones), 32'd0);
        check("midrst_idle", stall, 1'b0);
`else
        // Without the dump feature, dump_req has no effect
        dump_req = 1'b1;
        step();
        dump_req = 1'b0;
        check("nodump_stall", stall, 1'b0);
        check("nodump_valid", dump_valid, 1'b0);
        check("nodump_raddr", 32'(dump_raddr), 32'd0);
        check("nodump_ready", dbg_ready, 1'b1);
        step();
        check("nodump_done", dump_done, 1'b0);
        check("nodump_dirty", dump_dirty, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
